// File: rtl/alu_if_pkg.sv
// Shared types and constants for the byte-stream ALU front end.
// ALU_IF_FLAGS_EN adds the S_SEND_FLAGS state (flags byte after each result).
package alu_if_pkg;

`ifdef ALU_IF_FLAGS_EN
    typedef enum logic [2:0] {
        S_GET_A,
        S_GET_B,
        S_GET_OP,
        S_LOAD_OP,
        S_CAPTURE,
        S_SEND_RES,
        S_SEND_FLAGS
    } state_e;
`else
    typedef enum logic [2:0] {
        S_GET_A,
        S_GET_B,
        S_GET_OP,
        S_LOAD_OP,
        S_CAPTURE,
        S_SEND_RES
    } state_e;
`endif

    localparam logic [7:0] OP_ADD = 8'h80;
    localparam logic [7:0] OP_SUB = 8'h88;
    localparam logic [7:0] OP_AND = 8'h90;
    localparam logic [7:0] OP_OR  = 8'h94;
    localparam logic [7:0] OP_XOR = 8'h98;
    localparam logic [7:0] OP_NOR = 8'h9C;
    localparam logic [7:0] OP_SRL = 8'h08;
    localparam logic [7:0] OP_SRA = 8'h0C;

    localparam int unsigned FLAG_CARRY = 1;
    localparam int unsigned FLAG_ZERO  = 0;

endpackage

// File: rtl/alu_interface.sv
// Receives A, B, opcode bytes, strobes them into the ALU and returns the result byte.
// Define ALU_IF_FLAGS_EN to also return a {carry, zero} flags byte after each result.
module alu_interface
    import alu_if_pkg::*;
#(
    parameter int unsigned NB_DATA = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_rx_ready,
    output logic [NB_DATA-1:0] o_alu_data,
    output logic               o_enable_1,
    output logic               o_enable_2,
    output logic               o_enable_3,
    input  logic [NB_DATA-1:0] i_alu_data,
    input  logic               i_alu_carry,
    input  logic               i_alu_zero,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready
);

    state_e             state_q, state_d;
    logic               rx_ready_q, tx_valid_q;
    logic               en1_q, en2_q, en3_q;
    logic [NB_DATA-1:0] alu_data_q, tx_data_q;
    logic               rx_hs, tx_hs;

    assign rx_hs = i_rx_valid & rx_ready_q;
    assign tx_hs = tx_valid_q & i_tx_ready;

`ifdef ALU_IF_FLAGS_EN
    logic               carry_q, zero_q;
    logic [NB_DATA-1:0] flags_byte;

    always_comb begin
        flags_byte             = '0;
        flags_byte[FLAG_CARRY] = carry_q;
        flags_byte[FLAG_ZERO]  = zero_q;
    end
`else
    logic unused_flags;
    assign unused_flags = i_alu_carry ^ i_alu_zero;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_GET_A:    if (rx_hs) state_d = S_GET_B;
            S_GET_B:    if (rx_hs) state_d = S_GET_OP;
            S_GET_OP:   if (rx_hs) state_d = S_LOAD_OP;
            S_LOAD_OP:  state_d = S_CAPTURE;
            S_CAPTURE:  state_d = S_SEND_RES;
`ifdef ALU_IF_FLAGS_EN
            S_SEND_RES:   if (tx_hs) state_d = S_SEND_FLAGS;
            S_SEND_FLAGS: if (tx_hs) state_d = S_GET_A;
`else
            S_SEND_RES:   if (tx_hs) state_d = S_GET_A;
`endif
            default:    state_d = S_GET_A;
        endcase
    end

    // Handshake outputs are registered from the next state so they track state_q exactly.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= S_GET_A;
            rx_ready_q <= 1'b0;
            tx_valid_q <= 1'b0;
            en1_q      <= 1'b0;
            en2_q      <= 1'b0;
            en3_q      <= 1'b0;
            alu_data_q <= '0;
            tx_data_q  <= '0;
`ifdef ALU_IF_FLAGS_EN
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rx_ready_q <= (state_d == S_GET_A) || (state_d == S_GET_B) ||
                          (state_d == S_GET_OP);
`ifdef ALU_IF_FLAGS_EN
            tx_valid_q <= (state_d == S_SEND_RES) || (state_d == S_SEND_FLAGS);
`else
            tx_valid_q <= (state_d == S_SEND_RES);
`endif
            en1_q      <= rx_hs && (state_q == S_GET_A);
            en2_q      <= rx_hs && (state_q == S_GET_B);
            en3_q      <= rx_hs && (state_q == S_GET_OP);
            if (rx_hs) begin
                alu_data_q <= i_rx_data;
            end
            if (state_q == S_CAPTURE) begin
                tx_data_q <= i_alu_data;
`ifdef ALU_IF_FLAGS_EN
                carry_q   <= i_alu_carry;
                zero_q    <= i_alu_zero;
`endif
            end
`ifdef ALU_IF_FLAGS_EN
            if (tx_hs && (state_q == S_SEND_RES)) begin
                tx_data_q <= flags_byte;
            end
`endif
        end
    end

    assign o_rx_ready = rx_ready_q;
    assign o_tx_valid = tx_valid_q;
    assign o_alu_data = alu_data_q;
    assign o_tx_data  = tx_data_q;
    assign o_enable_1 = en1_q;
    assign o_enable_2 = en2_q;
    assign o_enable_3 = en3_q;

endmodule

// File: tb/tb_alu_interface.sv
// Scoreboard bench for alu_interface with a behavioural ALU model behind the load port.
module tb_alu_interface;

    logic       clk = 1'b0;
    logic       i_reset = 1'b0;
    logic [7:0] i_rx_data = 8'h00;
    logic       i_rx_valid = 1'b0;
    logic       o_rx_ready;
    logic [7:0] o_alu_data;
    logic       o_enable_1, o_enable_2, o_enable_3;
    logic [7:0] i_alu_data;
    logic       i_alu_carry, i_alu_zero;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       i_tx_ready = 1'b1;

    int checks = 0;
    int errors = 0;

    alu_interface #(.NB_DATA(8)) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .o_rx_ready (o_rx_ready),
        .o_alu_data (o_alu_data),
        .o_enable_1 (o_enable_1),
        .o_enable_2 (o_enable_2),
        .o_enable_3 (o_enable_3),
        .i_alu_data (i_alu_data),
        .i_alu_carry(i_alu_carry),
        .i_alu_zero (i_alu_zero),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready)
    );

    always #5 clk = ~clk;

    // ALU model: loads on the enable strobes, result is combinational.
    logic [7:0] a_r = 8'h00, b_r = 8'h00, op_r = 8'h00;
    logic [8:0] wide;
    always @(posedge clk) begin
        if (o_enable_1) a_r <= o_alu_data;
        if (o_enable_2) b_r <= o_alu_data;
        if (o_enable_3) op_r <= o_alu_data;
    end
    always_comb begin
        wide = 9'h000;
        case (op_r[7:2])
            6'h20: wide = {1'b0, a_r} + {1'b0, b_r};
            6'h22: wide = {1'b0, a_r} - {1'b0, b_r};
            6'h24: wide = {1'b0, a_r & b_r};
            6'h25: wide = {1'b0, a_r | b_r};
            6'h26: wide = {1'b0, a_r ^ b_r};
            6'h27: wide = {1'b0, ~(a_r | b_r)};
            6'h02: wide = {1'b0, a_r >> b_r[2:0]};
            6'h03: wide = {1'b0, 8'($signed(a_r) >>> b_r[2:0])};
            default: wide = 9'h000;
        endcase
    end
    assign i_alu_data  = wide[7:0];
    assign i_alu_carry = wide[8];
    assign i_alu_zero  = (wide[7:0] == 8'h00);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Cycle bookkeeping, all sampled on the falling edge.
    int   cyc = 0;
    int   en1_cnt, en2_cnt, en3_cnt, en1_cyc, en2_cyc, en3_cyc;
    int   last_hs_cyc = 0, tx_rise_cyc = 0;
    logic p1 = 0, p2 = 0, p3 = 0, ptxv = 0;
    logic [7:0] exp_q[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (i_reset) begin
            if (o_enable_1 | o_enable_2 | o_enable_3)
                chk("enable_onehot", $countones({o_enable_1, o_enable_2, o_enable_3}), 1);
            if (o_enable_1) begin chk("en1_repeat", p1, 0); en1_cnt++; en1_cyc = cyc; end
            if (o_enable_2) begin chk("en2_repeat", p2, 0); en2_cnt++; en2_cyc = cyc; end
            if (o_enable_3) begin chk("en3_repeat", p3, 0); en3_cnt++; en3_cyc = cyc; end
            if (i_rx_valid && o_rx_ready) last_hs_cyc = cyc;
            if (o_tx_valid && !ptxv) tx_rise_cyc = cyc;
            if (o_tx_valid && i_tx_ready) begin
                if (exp_q.size() == 0) begin
                    chk("tx_unexpected", 32'(o_tx_data), 32'hFFFF_FFFF);
                end else begin
                    chk("tx_byte", 32'(o_tx_data), 32'(exp_q.pop_front()));
                end
            end
        end
        p1 = o_enable_1; p2 = o_enable_2; p3 = o_enable_3; ptxv = o_tx_valid;
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        while (!o_rx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("rx_timeout", 1, 0);
        @(posedge clk);
        #1 i_rx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || !o_rx_ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 1, 0);
    endtask

    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                         input logic [7:0] res, input logic [7:0] flags, input string name);
        en1_cnt = 0; en2_cnt = 0; en3_cnt = 0;
        exp_q.push_back(res);
`ifdef ALU_IF_FLAGS_EN
        exp_q.push_back(flags);
`else
        if (flags === 8'hxx) $display("unreachable");
`endif
        send_byte(a);
        send_byte(b);
        send_byte(op);
        wait_idle();
        chk({name, "_en_counts"}, {en1_cnt[7:0], en2_cnt[7:0], en3_cnt[7:0]}, 32'h010101);
        chk({name, "_en2_after_en1"}, en2_cyc - en1_cyc, 1);
        chk({name, "_en3_after_en2"}, en3_cyc - en2_cyc, 1);
        chk({name, "_en3_after_ophs"}, en3_cyc - last_hs_cyc, 1);
        if (i_tx_ready) chk({name, "_txv_latency"}, tx_rise_cyc - last_hs_cyc, 3);
    endtask

    initial begin
        #23;
        chk("reset_rx_ready", o_rx_ready, 0);
        chk("reset_tx_valid", o_tx_valid, 0);
        chk("reset_tx_data", o_tx_data, 0);
        chk("reset_alu_data", o_alu_data, 0);
        chk("reset_enables", {o_enable_1, o_enable_2, o_enable_3}, 0);
        @(negedge clk);
        i_reset = 1'b1;

        do_op(8'h05, 8'h03, 8'h80, 8'h08, 8'h00, "add");
        do_op(8'h03, 8'h05, 8'h88, 8'hFE, 8'h02, "sub_borrow");
        do_op(8'hFF, 8'h01, 8'h80, 8'h00, 8'h03, "add_ovf");
        do_op(8'hAA, 8'h0F, 8'h98, 8'hA5, 8'h00, "xor");
        do_op(8'h80, 8'h03, 8'h08, 8'h10, 8'h00, "srl");
        do_op(8'h80, 8'h01, 8'h0C, 8'hC0, 8'h00, "sra");
        do_op(8'h0F, 8'hF0, 8'h9C, 8'h00, 8'h01, "nor");

        // Backpressure with an extra rx byte held valid the whole time.
        i_tx_ready = 1'b0;
        exp_q.push_back(8'h30);
`ifdef ALU_IF_FLAGS_EN
        exp_q.push_back(8'h00);
`endif
        send_byte(8'hF0);
        send_byte(8'h3C);
        send_byte(8'h90);
        begin
            int n = 0;
            while (!o_tx_valid && n < 20) begin @(negedge clk); n++; end
            chk("bp_txv_seen", o_tx_valid, 1);
        end
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_tx_valid", o_tx_valid, 1);
            chk("bp_tx_data", o_tx_data, 8'h30);
            chk("bp_rx_ready", o_rx_ready, 0);
        end
        i_rx_valid = 1'b0;
        i_tx_ready = 1'b1;
        wait_idle();
        do_op(8'h05, 8'h03, 8'h80, 8'h08, 8'h00, "add_after_bp");

        // Reset after operand A is accepted.
        send_byte(8'h11);
        @(negedge clk);
        i_reset = 1'b0;
        #1;
        chk("rst_rx_ready", o_rx_ready, 0);
        chk("rst_tx_valid", o_tx_valid, 0);
        chk("rst_tx_data", o_tx_data, 0);
        chk("rst_alu_data", o_alu_data, 0);
        chk("rst_enables", {o_enable_1, o_enable_2, o_enable_3}, 0);
        repeat (2) @(negedge clk);
        i_reset = 1'b1;
        do_op(8'h0F, 8'hF0, 8'h94, 8'hFF, 8'h00, "or_after_rst");

        repeat (3) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
